fwd_mux_stage: RTL and testbench

- Parametrised N-way operand-select stage for the pipelined core's forwarding path; successor to the fixed 3:1 operand mux.
- Selects one of NUM_IN signed operands, registers the result, and carries it across a valid/ready handshake.
- A 2-entry skid buffer gives full throughput under backpressure.
- Adds pipeline flush, out-of-range select detection, and a saturating forwarding-event counter for performance monitoring.

---
 rtl/pipe_pkg.sv | 25 ++
 rtl/fwd_skid_buf.sv | 92 +++++++++
 rtl/fwd_mux_stage.sv | 88 ++++++++
 tb/tb_fwd_mux_stage.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the forwarding-path operand select stage:
// source indices, buffer occupancy states and a ceil-log2 helper.
package pipe_pkg;

    localparam int unsigned FWD_SRC_RF    = 0;
    localparam int unsigned FWD_SRC_EXMEM = 1;
    localparam int unsigned FWD_SRC_MEMWB = 2;

    typedef enum logic [1:0] {
        BUF_EMPTY,
        BUF_ONE,
        BUF_TWO
    } buf_state_t;

    // Minimum of 1 so a select field never collapses to zero width.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned v = n - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/fwd_skid_buf.sv
// Two-entry skid buffer with flush: main register drives the output,
// the skid register absorbs one extra entry under backpressure.
module fwd_skid_buf
    import pipe_pkg::*;
#(
    parameter int unsigned DW = 34
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);

    buf_state_t    state;
    buf_state_t    state_nx;
    logic [DW-1:0] main_q;
    logic [DW-1:0] skid_q;
    logic          skid_valid;
    logic          accept;
    logic          fire;
    logic          load_main_in;
    logic          load_main_skid;
    logic          load_skid;

    assign out_valid  = (state != BUF_EMPTY);
    assign skid_valid = (state == BUF_TWO);
    assign in_ready   = !skid_valid && !flush && !rst;
    assign accept     = in_valid && in_ready;
    assign fire       = out_valid && out_ready;
    assign out_data   = main_q;

    // Flush only clears occupancy; main_q keeps its last value on purpose.
    always_comb begin
        state_nx       = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_nx = BUF_EMPTY;
        end else begin
            unique case (state)
                BUF_EMPTY: begin
                    if (accept) begin
                        state_nx     = BUF_ONE;
                        load_main_in = 1'b1;
                    end
                end
                BUF_ONE: begin
                    if (accept && fire) begin
                        load_main_in = 1'b1;
                    end else if (accept) begin
                        state_nx  = BUF_TWO;
                        load_skid = 1'b1;
                    end else if (fire) begin
                        state_nx = BUF_EMPTY;
                    end
                end
                BUF_TWO: begin
                    if (fire) begin
                        state_nx       = BUF_ONE;
                        load_main_skid = 1'b1;
                    end
                end
                default: state_nx = BUF_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= BUF_EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else begin
            state <= state_nx;
            if (load_main_in) begin
                main_q <= in_data;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_data;
            end
        end
    end

endmodule

// File: rtl/fwd_mux_stage.sv
// N-way signed operand select for the forwarding path, registered through
// a skid buffer, with sticky bad-select flag and saturating forward counter.
module fwd_mux_stage
    import pipe_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned NUM_IN = 4,
    parameter int unsigned SEL_W  = clog2(NUM_IN),
    parameter int unsigned CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic [NUM_IN*WIDTH-1:0] in_bus,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    sel_err,
    output logic [CNT_W-1:0]        fwd_cnt,
    input  logic                    cnt_clr
);

    localparam logic [SEL_W:0]   NUM_IN_EXT = (SEL_W + 1)'(NUM_IN);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    logic                   sel_ok;
    logic                   is_fwd;
    logic                   accept;
    logic [WIDTH-1:0]       sel_data;
    logic [SEL_W+WIDTH-1:0] buf_in;
    logic [SEL_W+WIDTH-1:0] buf_out;

    assign sel_ok = ({1'b0, in_sel} < NUM_IN_EXT);
    assign is_fwd = (in_sel != SEL_W'(FWD_SRC_RF));
    assign accept = in_valid && in_ready;

    // Out-of-range selects match no k and fall back to the register-file source.
    always_comb begin
        sel_data = in_bus[FWD_SRC_RF*WIDTH +: WIDTH];
        for (int unsigned k = 1; k < NUM_IN; k++) begin
            if (in_sel == SEL_W'(k)) begin
                sel_data = in_bus[k*WIDTH +: WIDTH];
            end
        end
    end

    assign buf_in = {in_sel, sel_data};

    fwd_skid_buf #(
        .DW(SEL_W + WIDTH)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (buf_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (buf_out)
    );

    assign out_sel  = buf_out[SEL_W+WIDTH-1 -: SEL_W];
    assign out_data = buf_out[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_cnt <= '0;
        end else if (cnt_clr) begin
            fwd_cnt <= '0;
        end else if (accept && is_fwd && (fwd_cnt != CNT_MAX)) begin
            fwd_cnt <= fwd_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_err <= 1'b0;
        end else if (accept && !sel_ok) begin
            sel_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fwd_mux_stage.sv
// Bench for fwd_mux_stage: a 4-source instance against a queue-based model
// plus a 3-source, 4-bit-counter instance for bad selects and saturation.
module tb_fwd_mux_stage;

    localparam int unsigned W   = 32;
    localparam int unsigned N   = 4;
    localparam int unsigned CW  = 16;
    localparam int unsigned NB  = 3;
    localparam int unsigned CWB = 4;

    logic          clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, flush, in_valid, in_ready, out_valid, out_ready, sel_err, cnt_clr;
    logic [1:0]    in_sel, out_sel;
    logic [N*W-1:0] in_bus;
    logic [W-1:0]  out_data;
    logic [CW-1:0] fwd_cnt;

    logic          b_rst, b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_sel_err, b_cnt_clr;
    logic [1:0]    b_in_sel, b_out_sel;
    logic [NB*W-1:0] b_in_bus;
    logic [W-1:0]  b_out_data;
    logic [CWB-1:0] b_fwd_cnt;

    fwd_mux_stage #(.WIDTH(W), .NUM_IN(N), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_sel(in_sel), .in_bus(in_bus), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_sel(out_sel), .sel_err(sel_err), .fwd_cnt(fwd_cnt),
        .cnt_clr(cnt_clr)
    );

    fwd_mux_stage #(.WIDTH(W), .NUM_IN(NB), .CNT_W(CWB)) dut_b (
        .clk(clk), .rst(b_rst), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_sel(b_in_sel), .in_bus(b_in_bus), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_data(b_out_data), .out_sel(b_out_sel), .sel_err(b_sel_err), .fwd_cnt(b_fwd_cnt),
        .cnt_clr(b_cnt_clr)
    );

    int passed = 0;
    int total  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Reference model: an ordered queue of at most two pending results.
    typedef struct packed {
        logic [W-1:0] data;
        logic [1:0]   sel;
    } ent_t;

    ent_t         q[$];
    logic [W-1:0] m_data;
    logic [1:0]   m_sel;
    int unsigned  m_cnt;
    bit           m_err;

    function automatic logic [W-1:0] pick(input logic [1:0] s, input logic [N*W-1:0] bus);
        int unsigned idx;
        idx = (int'(s) < N) ? int'(s) : 0;
        return bus[idx*W +: W];
    endfunction

    task automatic drive_a(input bit v, input logic [1:0] s, input bit ordy,
                           input bit fl, input bit r, input bit clr);
        in_valid  = v;
        in_sel    = s;
        out_ready = ordy;
        flush     = fl;
        rst       = r;
        cnt_clr   = clr;
        @(negedge clk);
        chk("m_in_ready",  64'(in_ready),  64'((q.size() < 2) && !fl && !r));
        chk("m_out_valid", 64'(out_valid), 64'(q.size() > 0));
        chk("m_out_data",  64'(out_data),  64'(m_data));
        chk("m_out_sel",   64'(out_sel),   64'(m_sel));
        chk("m_fwd_cnt",   64'(fwd_cnt),   64'(m_cnt));
        chk("m_sel_err",   64'(sel_err),   64'(m_err));
    endtask

    task automatic tick_a();
        bit   acc, fire;
        ent_t e;
        @(posedge clk);
        acc    = in_valid && (q.size() < 2) && !flush && !rst;
        fire   = (q.size() > 0) && out_ready && !flush && !rst;
        e.data = pick(in_sel, in_bus);
        e.sel  = in_sel;
        if (rst) begin
            q.delete();
            m_data = '0;
            m_sel  = '0;
            m_cnt  = 0;
            m_err  = 1'b0;
        end else begin
            if (flush) q.delete();
            else begin
                if (fire) void'(q.pop_front());
                if (acc) q.push_back(e);
            end
            if (cnt_clr) m_cnt = 0;
            else if (acc && in_sel != 2'd0 && m_cnt < (2**CW - 1)) m_cnt++;
            if (acc && int'(in_sel) >= N) m_err = 1'b1;
            if (q.size() > 0) begin
                m_data = q[0].data;
                m_sel  = q[0].sel;
            end
        end
        #1;
    endtask

    task automatic b_drive(input bit v, input logic [1:0] s, input bit clr,
                           input bit fl, input bit r);
        b_in_valid = v;
        b_in_sel   = s;
        b_cnt_clr  = clr;
        b_flush    = fl;
        b_rst      = r;
        @(negedge clk);
    endtask

    task automatic b_tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit           v;
        logic [1:0]   sel;
        bit           ordy;
        bit           exp_rdy;
        bit           exp_ov;
        logic [W-1:0] exp_data;
        int unsigned  exp_cnt;
    } vec_t;

    vec_t tbl[6];

    initial begin
        tbl[0] = '{1'b1, 2'd0, 1'b1, 1'b1, 1'b0, 32'h0,        0};
        tbl[1] = '{1'b1, 2'd1, 1'b1, 1'b1, 1'b1, 32'h1,        0};
        tbl[2] = '{1'b1, 2'd2, 1'b1, 1'b1, 1'b1, 32'hFFFFFFFE, 1};
        tbl[3] = '{1'b1, 2'd3, 1'b1, 1'b1, 1'b1, 32'h3,        2};
        tbl[4] = '{1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 32'h4,        3};
        tbl[5] = '{1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 32'h4,        3};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_sel = '0; out_ready = 1'b0; cnt_clr = 1'b0;
        in_bus = {32'h4, 32'h3, 32'hFFFFFFFE, 32'h1};
        b_rst = 1'b1; b_flush = 1'b0; b_in_valid = 1'b0; b_in_sel = '0; b_out_ready = 1'b1;
        b_cnt_clr = 1'b0;
        b_in_bus = {32'h30, 32'h20, 32'h10};
        q.delete(); m_data = '0; m_sel = '0; m_cnt = 0; m_err = 1'b0;
        tick_a();

        // Streaming after reset: row 0 also covers the reset state.
        for (int i = 0; i < 6; i++) begin
            drive_a(tbl[i].v, tbl[i].sel, tbl[i].ordy, 1'b0, 1'b0, 1'b0);
            chk($sformatf("stream%0d_rdy", i),  64'(in_ready),  64'(tbl[i].exp_rdy));
            chk($sformatf("stream%0d_ov", i),   64'(out_valid), 64'(tbl[i].exp_ov));
            chk($sformatf("stream%0d_data", i), 64'(out_data),  64'(tbl[i].exp_data));
            chk($sformatf("stream%0d_cnt", i),  64'(fwd_cnt),   64'(tbl[i].exp_cnt));
            tick_a();
        end

        // Backpressure: A = src1, B = src2.
        drive_a(1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("bp_rdy_a", 64'(in_ready), 64'(1));
        tick_a();
        drive_a(1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("bp_rdy_b", 64'(in_ready), 64'(1));
        chk("bp_data_a0", 64'(out_data), 64'(32'hFFFFFFFE));
        tick_a();
        drive_a(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("bp_rdy_full", 64'(in_ready), 64'(0));
        chk("bp_data_a1", 64'(out_data), 64'(32'hFFFFFFFE));
        tick_a();
        drive_a(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("bp_data_a2", 64'(out_data), 64'(32'hFFFFFFFE));
        tick_a();
        drive_a(1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("bp_fire_a", 64'(out_data), 64'(32'hFFFFFFFE));
        chk("bp_rdy_fire", 64'(in_ready), 64'(0));
        tick_a();
        drive_a(1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("bp_rdy_back", 64'(in_ready), 64'(1));
        chk("bp_data_b", 64'(out_data), 64'(32'h3));
        chk("bp_sel_b", 64'(out_sel), 64'(2));
        tick_a();
        drive_a(1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("bp_drained", 64'(out_valid), 64'(0));
        chk("bp_cnt", 64'(fwd_cnt), 64'(5));
        tick_a();

        // Flush while TWO with a simultaneous valid input.
        drive_a(1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        tick_a();
        drive_a(1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick_a();
        drive_a(1'b1, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("fl_rdy", 64'(in_ready), 64'(0));
        tick_a();
        drive_a(1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("fl_ov", 64'(out_valid), 64'(0));
        chk("fl_skid_empty", 64'(in_ready), 64'(1));
        chk("fl_cnt", 64'(fwd_cnt), 64'(7));
        chk("fl_data_hold", 64'(out_data), 64'(32'h4));
        tick_a();

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            in_bus = {$urandom, $urandom, $urandom, $urandom};
            drive_a($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), $urandom_range(0, 2) != 0,
                    $urandom_range(0, 15) == 0, $urandom_range(0, 99) == 0,
                    $urandom_range(0, 31) == 0);
            tick_a();
        end

        // Reset while TWO.
        drive_a(1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick_a();
        drive_a(1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick_a();
        drive_a(1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        tick_a();
        drive_a(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("rst_rdy", 64'(in_ready), 64'(0));
        tick_a();
        drive_a(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_ov", 64'(out_valid), 64'(0));
        chk("rst_data", 64'(out_data), 64'(0));
        chk("rst_cnt", 64'(fwd_cnt), 64'(0));
        chk("rst_err", 64'(sel_err), 64'(0));
        chk("rst_rdy_after", 64'(in_ready), 64'(1));
        tick_a();

        // 3-source instance: bad select, stickiness, saturation, clear.
        b_tick();
        b_drive(1'b1, 2'd3, 1'b0, 1'b0, 1'b0);
        chk("b_rdy", 64'(b_in_ready), 64'(1));
        chk("b_err0", 64'(b_sel_err), 64'(0));
        b_tick();
        b_drive(1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
        chk("b_bad_data", 64'(b_out_data), 64'(32'h10));
        chk("b_bad_sel", 64'(b_out_sel), 64'(3));
        chk("b_err1", 64'(b_sel_err), 64'(1));
        chk("b_cnt1", 64'(b_fwd_cnt), 64'(1));
        b_tick();
        b_drive(1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
        b_tick();
        b_drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        chk("b_err_flush", 64'(b_sel_err), 64'(1));
        chk("b_ov_flush", 64'(b_out_valid), 64'(0));
        chk("b_cnt2", 64'(b_fwd_cnt), 64'(2));
        b_tick();
        for (int i = 0; i < 20; i++) begin
            b_drive(1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
            chk($sformatf("b_sat%0d", i), 64'(b_fwd_cnt), 64'((2 + i > 15) ? 15 : 2 + i));
            b_tick();
        end
        b_drive(1'b1, 2'd2, 1'b1, 1'b0, 1'b0);
        chk("b_cnt_sat", 64'(b_fwd_cnt), 64'(15));
        b_tick();
        b_drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        chk("b_cnt_clr", 64'(b_fwd_cnt), 64'(0));
        chk("b_err_kept", 64'(b_sel_err), 64'(1));
        b_tick();
        b_drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
        b_tick();
        b_drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        chk("b_err_rst", 64'(b_sel_err), 64'(0));
        chk("b_data_rst", 64'(b_out_data), 64'(0));
        chk("b_ov_rst", 64'(b_out_valid), 64'(0));
        b_tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
